// File: rtl/inv_cipher_core.sv
// Iterative AES-128 inverse cipher: one decryption round per clock, round keys
// fetched from an external schedule through rk_addr/rk_data.
module inv_cipher_core (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] ct_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] pt_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   rk_addr,
    input  logic [127:0] rk_data
);

    typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_t;

    state_t       state_r;
    logic [127:0] blk_r;
    logic [3:0]   rnd_r;
    logic         in_ready_r;
    logic         out_valid_r;
    logic [3:0]   rk_addr_r;

    logic [7:0]   byte_s [16];
    logic [127:0] shift_s;
    logic [127:0] sub_s;
    logic [127:0] ark_s;
    logic [127:0] mix_s;
    logic [127:0] round_s;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (b[i] ? sh : 8'h00);
            sh  = xtime(sh);
        end
        return acc;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] t;
        t = {a[1:0], a[7:2]} ^ {a[4:0], a[7:5]} ^ {a[6:0], a[7]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    // Split the state into bytes s0..s15, s0 being the most significant byte
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            byte_s[i] = blk_r[8*(15-i) +: 8];
        end
    end

    assign shift_s = {byte_s[0],  byte_s[13], byte_s[10], byte_s[7],
                      byte_s[4],  byte_s[1],  byte_s[14], byte_s[11],
                      byte_s[8],  byte_s[5],  byte_s[2],  byte_s[15],
                      byte_s[12], byte_s[9],  byte_s[6],  byte_s[3]};

    // InvSubBytes, AddRoundKey, then InvMixColumns except on the final round
    always_comb begin
        sub_s   = 128'h0;
        mix_s   = 128'h0;
        ark_s   = 128'h0;
        round_s = 128'h0;
        for (int i = 0; i < 16; i++) begin
            sub_s[8*i +: 8] = inv_sbox(shift_s[8*i +: 8]);
        end
        ark_s = sub_s ^ rk_data;
        for (int c = 0; c < 4; c++) begin
            mix_s[32*c +: 32] = inv_mix_col(ark_s[32*c +: 32]);
        end
        if (rnd_r != 4'd0) begin
            round_s = mix_s;
        end else begin
            round_s = ark_s;
        end
    end

    // Control FSM; handshake and key-address outputs are registered next to the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            blk_r       <= 128'h0;
            rnd_r       <= 4'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            rk_addr_r   <= 4'd10;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        blk_r      <= ct_in ^ rk_data;
                        rnd_r      <= 4'd9;
                        state_r    <= ROUND;
                        in_ready_r <= 1'b0;
                        rk_addr_r  <= 4'd9;
                    end
                end
                ROUND: begin
                    blk_r <= round_s;
                    if (rnd_r != 4'd0) begin
                        rnd_r     <= rnd_r - 4'd1;
                        rk_addr_r <= rnd_r - 4'd1;
                    end else begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                        rk_addr_r   <= 4'd10;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    rk_addr_r   <= 4'd10;
                end
            endcase
        end
    end

    assign pt_out    = blk_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign rk_addr   = rk_addr_r;

endmodule

// File: tb/tb_inv_cipher_core.sv
// Bench for inv_cipher_core: a behavioural AES model (own key expansion and
// table-derived inverse S-box) predicts every output each cycle.
`timescale 1ns/1ps
module tb_inv_cipher_core;

    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] ct_in = 128'h0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] pt_out;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] rk_tab [11];

    inv_cipher_core dut (
        .clk(clk), .rst_n(rst_n), .ct_in(ct_in), .in_valid(in_valid), .in_ready(in_ready),
        .pt_out(pt_out), .out_valid(out_valid), .out_ready(out_ready),
        .rk_addr(rk_addr), .rk_data(rk_data)
    );

    always #5 clk = ~clk;

    assign rk_data = (rk_addr <= 4'd10) ? rk_tab[rk_addr] : 128'h0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Polynomial product then reduction modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (int'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (32'h11b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, s;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = 8'(x);
        end
    endtask

    task automatic set_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [7:0] byte_of(input logic [127:0] v, input int r, input int c);
        return v[127-8*(4*c+r) -: 8];
    endfunction

    // Textbook inverse cipher on a row/column byte matrix
    function automatic logic [127:0] ref_dec(input logic [127:0] ct);
        logic [7:0]   st [4][4];
        logic [7:0]   tmp [4][4];
        logic [7:0]   coef [4];
        logic [127:0] res;
        coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) st[r][c] = byte_of(ct, r, c) ^ byte_of(rk_tab[10], r, c);
        for (int rd = 9; rd >= 0; rd--) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) tmp[r][(c + r) % 4] = st[r][c];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) st[r][c] = isbox[tmp[r][c]] ^ byte_of(rk_tab[rd], r, c);
            if (rd != 0) begin
                for (int c = 0; c < 4; c++) begin
                    for (int k = 0; k < 4; k++) begin
                        tmp[k][c] = 8'h00;
                        for (int j = 0; j < 4; j++) tmp[k][c] = tmp[k][c] ^ gmul(coef[(j - k + 4) % 4], st[j][c]);
                    end
                    for (int k = 0; k < 4; k++) st[k][c] = tmp[k][c];
                end
            end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) res[127-8*(4*c+r) -: 8] = st[r][c];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Timing model: m_cnt = -1 idle, 1..10 rounds in flight, 11 result presented
    int           m_cnt = -1;
    logic [127:0] m_exp = 128'h0;
    logic         m_clean = 1'b1;
    int           n_acc = 0;
    int           acc_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt   <= -1;
            m_clean <= 1'b1;
        end else if (m_cnt < 0) begin
            if (in_valid) begin
                m_cnt   <= 1;
                m_exp   <= ref_dec(ct_in);
                m_clean <= 1'b0;
                n_acc   <= n_acc + 1;
                acc_cyc.push_back(cyc);
            end
        end else if (m_cnt < 11) begin
            m_cnt <= m_cnt + 1;
        end else if (out_ready) begin
            m_cnt <= -1;
        end
    end

    always @(posedge clk) begin
        #2;
        chk("in_ready", in_ready, m_cnt < 0);
        chk("out_valid", out_valid, m_cnt == 11);
        chk("rk_addr", rk_addr, (m_cnt >= 1 && m_cnt <= 10) ? 128'(10 - m_cnt) : 128'd10);
        if (m_cnt == 11) chk("pt_out", pt_out, m_exp);
        else if (m_clean) chk("pt_after_reset", pt_out, 128'h0);
    end

    task automatic send(input logic [127:0] ct);
        int n;
        n = 0;
        @(negedge clk);
        ct_in = ct;
        in_valid = 1'b1;
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
        ct_in = rand128();
    endtask

    task automatic wait_out(input string name, input logic [127:0] exp);
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid"}, out_valid, 1'b1);
        chk(name, pt_out, exp);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_cnt >= 0 && n < 100) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        if (m_cnt >= 0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: block still in flight, required idle");
        end
    endtask

    initial begin
        int a0, n;
        logic [127:0] held;

        build_sbox();
        chk("isbox_00", isbox[8'h00], 8'h52);
        chk("isbox_63", isbox[8'h63], 8'h00);
        chk("isbox_ff", isbox[8'hff], 8'h7d);
        set_key(B_KEY);
        chk("model_b", ref_dec(B_CT), B_PT);
        set_key(C1_KEY);
        chk("rk10_c1", rk_tab[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        chk("model_c1", ref_dec(C1_CT), C1_PT);

        // C.1 accepted on the first cycle after release; rk_addr sequence and latency
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ct_in = C1_CT;
        in_valid = 1'b1;
        chk("seq_in_ready", in_ready, 1'b1);
        chk("seq_addr_0", rk_addr, 4'd10);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1) begin
                in_valid = 1'b0;
                ct_in = rand128();
            end
            chk("seq_addr", rk_addr, (k <= 10) ? 128'(10 - k) : 128'd10);
            chk("seq_latency", out_valid, k == 11);
        end
        chk("c1_pt", pt_out, C1_PT);

        // FIPS-197 appendix B
        set_key(B_KEY);
        send(B_CT);
        wait_out("b_pt", B_PT);

        // Backpressure: result held, input side ignored
        @(negedge clk);
        set_key(C1_KEY);
        out_ready = 1'b0;
        send(C1_CT);
        wait_out("bp_first", C1_PT);
        held = pt_out;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_pt", pt_out, held);
            chk("bp_in_ready", in_ready, 1'b0);
            in_valid = 1'($urandom_range(0, 1));
            ct_in = rand128();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", in_ready, 1'b1);
        chk("bp_release_valid", out_valid, 1'b0);

        // Back-to-back C.1 then B with in_valid held high
        set_key(C1_KEY);
        @(negedge clk);
        a0 = n_acc;
        ct_in = C1_CT;
        in_valid = 1'b1;
        n = 0;
        while (n_acc < a0 + 1 && n < 40) begin @(negedge clk); n++; end
        ct_in = B_CT;
        wait_out("b2b_c1", C1_PT);
        set_key(B_KEY);
        n = 0;
        while (n_acc < a0 + 2 && n < 40) begin @(negedge clk); n++; end
        in_valid = 1'b0;
        chk("b2b_accepts", n_acc, a0 + 2);
        if (n_acc >= a0 + 2) chk("b2b_gap", acc_cyc[a0+1] - acc_cyc[a0], 12);
        wait_out("b2b_b", B_PT);

        // Reset in the middle of a block
        @(negedge clk);
        set_key(C1_KEY);
        send(C1_CT);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_addr", rk_addr, 4'd10);
        chk("rst_pt", pt_out, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send(C1_CT);
        wait_out("post_rst_c1", C1_PT);

        // Randomised blocks, keys and backpressure
        for (int b = 0; b < 20; b++) begin
            wait_idle();
            set_key(rand128());
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(rand128());
        end
        wait_idle();
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inv_cipher_core.md
INV_CIPHER_CORE -- requirements
Module: inv_cipher_core

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-002 SHALL have these ports: ct_in in 128, ciphertext; byte s0 = [127:120] through s15 = [7:0], column-major (s0..s3 = column 0).
REQ-003 SHALL have in_valid in 1 and in_ready out 1: input handshake.
REQ-004 SHALL have pt_out out 128, plaintext, same byte order as ct_in.
REQ-005 SHALL have out_valid out 1 and out_ready in 1: output handshake.
REQ-006 SHALL have rk_addr out 4, round-key index 0..10.
REQ-007 SHALL have rk_data in 128, round key for rk_addr, combinational same-cycle return, same byte order as ct_in.

Function
REQ-008 SHALL implement the FIPS-197 AES-128 inverse cipher, iterative, one round per cycle; the key schedule is external.
REQ-009 SHALL implement FSM states IDLE, ROUND, DONE.
REQ-010 IDLE: in_ready=1, rk_addr=10; on in_valid&&in_ready, state_reg <= ct_in ^ rk_data, rnd <= 9, go to ROUND.
REQ-011 ROUND: in_ready=0, rk_addr=rnd; each cycle state_reg <= f(state_reg, rk_data), where f = InvShiftRows, then InvSubBytes, then XOR rk_data, then InvMixColumns when rnd != 0.
REQ-012 ROUND with rnd != 0: rnd decrements.
REQ-013 ROUND with rnd == 0: skip InvMixColumns, go to DONE.
REQ-014 InvShiftRows mapping SHALL be out = {s0,s13,s10,s7, s4,s1,s14,s11, s8,s5,s2,s15, s12,s9,s6,s3}.
REQ-015 InvSubBytes SHALL be 16 parallel instances of the FIPS-197 inverse S-box table (0x00->0x52, 0x63->0x00, 0xFF->0x7D).
REQ-016 InvMixColumns SHALL be per column, coefficients {0e,0b,0d,09} circulant, in GF(2^8) with polynomial 0x11B.
REQ-017 DONE: out_valid=1, pt_out=state_reg, rk_addr=10; pt_out stable while out_valid && !out_ready.
REQ-018 DONE with out_ready=1: go to IDLE next cycle.
REQ-019 in_ready and out_valid SHALL never both be 1.
REQ-020 in_valid SHALL be ignored outside IDLE; ct_in SHALL be sampled only on the accept cycle.
REQ-021 Latency: if accept occurs in cycle T, out_valid SHALL first be 1 in cycle T+11.
REQ-022 Minimum accept-to-accept interval SHALL be 12 cycles (out_ready held 1).
REQ-023 pt_out SHALL equal state_reg in all states; it is only meaningful while out_valid=1.
REQ-024 rk_addr SHALL be a registered-state decode only, with no combinational path from any input.
REQ-025 in_ready and out_valid SHALL be decoded from FSM state only, with no combinational path from in_valid or out_ready.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, state_reg=0, rnd=0, out_valid=0, in_ready=1, rk_addr=10, pt_out=0.
REQ-027 Reset asserted mid-ROUND or in DONE SHALL abandon the block with no output; the first accept after release SHALL behave per REQ-021.
REQ-028 Release of rst_n SHALL be synchronous to clk; in_valid asserted in the first cycle after release SHALL be accepted.

Verification
REQ-029 FIPS-197 C.1: ct=69c4e0d86a7b0430d8cdb78070b4c55a, key model supplies the expanded schedule of 000102030405060708090a0b0c0d0e0f (rk10=13111d7fe3944a17f307a78b4d2b30c5) -> pt_out=00112233445566778899aabbccddeeff at T+11.
REQ-030 FIPS-197 B: ct=3925841d02dc09fbdc118597196a0b32, key 2b7e151628aed2a6abf7158809cf4f3c -> pt_out=3243f6a8885a308d313198a2e0370734.
REQ-031 Monitor rk_addr over one block -> sequence 10 (accept cycle), 9,8,...,0, then 10.
REQ-032 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and pt_out held constant, in_ready=0, toggling ct_in/in_valid has no effect; out_ready=1 -> IDLE next cycle.
REQ-033 Back-to-back C.1 then B with in_valid held high and out_ready=1 -> accepts exactly 12 cycles apart, both results correct.
REQ-034 rst_n pulsed low at cycle T+5 of a block -> out_valid stays 0, outputs per REQ-026; a fresh C.1 block afterwards passes.
